// File: rtl/latch_ctrl_pkg.sv
// Shared types for the latch bank write controller.
// State encoding, op codes and the two-way round-robin pick.
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_GATE,
    ST_HOLD
  } state_e;

  localparam logic OP_WRITE  = 1'b0;
  localparam logic OP_PRESET = 1'b1;

  // ptr names the requester that wins a tie
  function automatic logic [1:0] rr_pick(
    input logic [1:0] req,
    input logic       ptr
  );
    logic [1:0] g;
    g = 2'b00;
    unique case (1'b1)
      (req == 2'b00): g = 2'b00;
      (req == 2'b01): g = 2'b01;
      (req == 2'b10): g = 2'b10;
      default:        g = ptr ? 2'b10 : 2'b01;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Pointer flips to the loser whenever a grant is taken.
module rr_arb2
  import latch_ctrl_pkg::*;
(
  input  logic       C,
  input  logic       R,
  input  logic [1:0] REQ,
  input  logic       ADV,
  output logic [1:0] GNT
);

  logic ptr_q;
  logic ptr_d;

  assign GNT = rr_pick(REQ, ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (ADV && (GNT != 2'b00)) begin
      ptr_d = GNT[0];
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Sequences writes/presets into a bank of gated latches.
// Every output is a flop; next values come from the FSM below.
module latch_bank_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ADDR_W      = 2,
  parameter int GATE_CYCLES = 1,
  parameter int INIT_PRESET = 1
) (
  input  logic                     C,
  input  logic                     R,
  input  logic [1:0]               REQ,
  input  logic [1:0]               OP,
  input  logic [ADDR_W-1:0]        ADDR0,
  input  logic [ADDR_W-1:0]        ADDR1,
  input  logic [WIDTH-1:0]         DATA0,
  input  logic [WIDTH-1:0]         DATA1,
  output logic [1:0]               ACK,
  output logic [WIDTH-1:0]         LD,
  output logic [(1<<ADDR_W)-1:0]   LG_N,
  output logic [(1<<ADDR_W)-1:0]   LPRE,
  output logic                     BUSY
);

  localparam int WORDS = 1 << ADDR_W;
  localparam int CNT_W = $clog2(GATE_CYCLES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                id_q, id_d;
  logic [WIDTH-1:0]    ld_q, ld_d;
  logic [WORDS-1:0]    lg_n_q, lg_n_d;
  logic [WORDS-1:0]    lpre_q, lpre_d;
  logic [1:0]          ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [1:0]          gnt;
  logic                adv;

  rr_arb2 u_arb (
    .C   (C),
    .R   (R),
    .REQ (REQ),
    .ADV (adv),
    .GNT (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    id_d    = id_q;
    ld_d    = ld_q;
    lg_n_d  = '1;
    lpre_d  = '0;
    ack_d   = 2'b00;
    adv     = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (cnt_q != '0) begin
          lpre_d = '1;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (REQ != 2'b00) begin
          adv = 1'b1;
          unique case (1'b1)
            gnt[0]: begin
              id_d   = 1'b0;
              op_d   = OP[0];
              addr_d = ADDR0;
              ld_d   = DATA0;
            end
            gnt[1]: begin
              id_d   = 1'b1;
              op_d   = OP[1];
              addr_d = ADDR1;
              ld_d   = DATA1;
            end
          endcase
          if (op_d == OP_PRESET) begin
            ld_d = '1;
          end
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_d = ST_GATE;
        cnt_d   = CNT_W'(GATE_CYCLES - 1);
        if (op_q == OP_PRESET) begin
          lpre_d[addr_q] = 1'b1;
        end else begin
          lg_n_d[addr_q] = 1'b0;
        end
      end

      ST_GATE: begin
        if (cnt_q == '0) begin
          state_d    = ST_HOLD;
          ack_d[id_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (op_q == OP_PRESET) begin
            lpre_d[addr_q] = 1'b1;
          end else begin
            lg_n_d[addr_q] = 1'b0;
          end
        end
      end

      ST_HOLD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Reset drops every gate at once; an interrupted op never ACKs.
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= (INIT_PRESET != 0) ? ST_INIT : ST_IDLE;
      cnt_q   <= CNT_W'(GATE_CYCLES);
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      id_q    <= 1'b0;
      ld_q    <= '0;
      lg_n_q  <= '1;
      lpre_q  <= '0;
      ack_q   <= 2'b00;
      busy_q  <= (INIT_PRESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      ld_q    <= ld_d;
      lg_n_q  <= lg_n_d;
      lpre_q  <= lpre_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ACK  = ack_q;
  assign LD   = ld_q;
  assign LG_N = lg_n_q;
  assign LPRE = lpre_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Bench for latch_bank_write_ctrl: GATE_CYCLES=1 with init preset,
// and GATE_CYCLES=3 without, each with a latch model and scoreboard.
module tb_latch_bank_write_ctrl;

  typedef struct {
    int         who;
    logic [1:0] addr;
    logic [3:0] val;
  } exp_t;

  logic       C = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  bit         armed = 1'b0;

  logic       r1, r3;
  logic [1:0] req1, op1, req3, op3;
  logic [1:0] a0_1, a1_1, a0_3, a1_3;
  logic [3:0] d0_1, d1_1, d0_3, d1_3;
  logic [1:0] ack1, ack3;
  logic [3:0] ld1, lgn1, lpre1, ld3, lgn3, lpre3;
  logic       busy1, busy3;

  logic [3:0] mem1 [4];
  logic [3:0] mem3 [4];
  exp_t       q1[$];
  exp_t       q3[$];
  exp_t       e1, e3;

  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;

  latch_bank_write_ctrl #(
    .WIDTH(4), .ADDR_W(2), .GATE_CYCLES(1), .INIT_PRESET(1)
  ) dut1 (
    .C(C), .R(r1), .REQ(req1), .OP(op1),
    .ADDR0(a0_1), .ADDR1(a1_1), .DATA0(d0_1), .DATA1(d1_1),
    .ACK(ack1), .LD(ld1), .LG_N(lgn1), .LPRE(lpre1), .BUSY(busy1)
  );

  latch_bank_write_ctrl #(
    .WIDTH(4), .ADDR_W(2), .GATE_CYCLES(3), .INIT_PRESET(0)
  ) dut3 (
    .C(C), .R(r3), .REQ(req3), .OP(op3),
    .ADDR0(a0_3), .ADDR1(a1_3), .DATA0(d0_3), .DATA1(d1_3),
    .ACK(ack3), .LD(ld3), .LG_N(lgn3), .LPRE(lpre3), .BUSY(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  function automatic bit inv_ok(input logic [3:0] lgn,
                                input logic [3:0] lpre);
    int nz, np;
    nz = $countones(~lgn);
    np = $countones(lpre);
    if (nz > 1) return 1'b0;
    if (np > 1 && lpre != 4'hF) return 1'b0;
    if (nz != 0 && np != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Transparent latch bank models
  always @(negedge C) begin
    for (int i = 0; i < 4; i++) begin
      if (lpre1[i] === 1'b1) mem1[i] <= 4'hF;
      else if (lgn1[i] === 1'b0) mem1[i] <= ld1;
      if (lpre3[i] === 1'b1) mem3[i] <= 4'hF;
      else if (lgn3[i] === 1'b0) mem3[i] <= ld3;
    end
  end

  always @(negedge C) begin
    if (armed) begin
      chk("inv1", 32'(inv_ok(lgn1, lpre1)), 1);
      chk("inv3", 32'(inv_ok(lgn3, lpre3)), 1);
      if (ack1 != 2'b00) begin
        chk("ack1_onehot", $countones(ack1), 1);
        if (q1.size() == 0) begin
          chk("ack1_unexpected", 32'(ack1), 0);
        end else begin
          e1 = q1.pop_front();
          chk("ack1_who", 32'(ack1), 32'(2'b01 << e1.who));
          chk("mem1_word", 32'(mem1[e1.addr]), 32'(e1.val));
        end
      end
      if (ack3 != 2'b00) begin
        if (q3.size() == 0) begin
          chk("ack3_unexpected", 32'(ack3), 0);
        end else begin
          e3 = q3.pop_front();
          chk("ack3_who", 32'(ack3), 32'(2'b01 << e3.who));
          chk("mem3_word", 32'(mem3[e3.addr]), 32'(e3.val));
        end
      end
    end
  end

  initial begin
    int last;
    r1 = 1'b1; r3 = 1'b1;
    req1 = 0; op1 = 0; a0_1 = 0; a1_1 = 0; d0_1 = 0; d1_1 = 0;
    req3 = 0; op3 = 0; a0_3 = 0; a1_3 = 0; d0_3 = 0; d1_3 = 0;

    // reset and init preset
    tick();
    armed = 1'b1;
    chk("rst_lgn", 32'(lgn1), 32'hF);
    chk("rst_lpre", 32'(lpre1), 0);
    chk("rst_ack", 32'(ack1), 0);
    chk("rst_ld", 32'(ld1), 0);
    chk("rst_busy", 32'(busy1), 1);
    chk("rst3_busy", 32'(busy3), 0);
    r1 = 1'b0; r3 = 1'b0;
    tick();
    chk("init_lpre", 32'(lpre1), 32'hF);
    chk("init_busy", 32'(busy1), 1);
    tick();
    chk("idle_lpre", 32'(lpre1), 0);
    chk("idle_busy", 32'(busy1), 0);

    // single write: word 2 <= A
    req1 = 2'b01; op1 = 2'b00; a0_1 = 2'd2; d0_1 = 4'hA;
    q1.push_back('{0, 2'd2, 4'hA});
    tick();
    chk("w_setup_ld", 32'(ld1), 32'hA);
    chk("w_setup_lgn", 32'(lgn1), 32'hF);
    tick();
    chk("w_gate_lgn", 32'(lgn1), 32'hB);
    chk("w_gate_ld", 32'(ld1), 32'hA);
    tick();
    chk("w_hold_ack", 32'(ack1), 32'h1);
    chk("w_hold_lgn", 32'(lgn1), 32'hF);
    req1 = 2'b00;
    tick();
    chk("w_idle_ack", 32'(ack1), 0);
    chk("w_idle_busy", 32'(busy1), 0);

    // both requesting from reset: alternate 0,1,0,1
    r1 = 1'b1; req1 = 2'b11; op1 = 2'b00;
    a0_1 = 2'd0; d0_1 = 4'h3; a1_1 = 2'd1; d1_1 = 4'h5;
    tick();
    r1 = 1'b0;
    q1.push_back('{0, 2'd0, 4'h3});
    q1.push_back('{1, 2'd1, 4'h5});
    q1.push_back('{0, 2'd0, 4'h7});
    q1.push_back('{1, 2'd1, 4'h9});
    last = 0;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 30 && ack1 == 2'b00; t++) tick();
      if (ack1 == 2'b00) begin
        chk("rr_timeout", 0, 1);
        break;
      end
      if (k > 0) chk("rr_spacing", 32'(cyc - last), 4);
      last = cyc;
      if (ack1[0]) d0_1 = 4'h7;
      if (ack1[1]) d1_1 = 4'h9;
      if (k == 3) req1 = 2'b00;
      tick();
    end

    // reset during GATE aborts, reissue completes
    req1 = 2'b01; op1 = 2'b00; a0_1 = 2'd1; d0_1 = 4'h6;
    tick();
    tick();
    chk("ab_gate_lgn", 32'(lgn1), 32'hD);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    chk("ab_lgn", 32'(lgn1), 32'hF);
    chk("ab_lpre", 32'(lpre1), 0);
    chk("ab_ack", 32'(ack1), 0);
    d0_1 = 4'hC;
    q1.push_back('{0, 2'd1, 4'hC});
    for (int t = 0; t < 20 && ack1 == 2'b00; t++) tick();
    chk("ab_reissue_ack", 32'(ack1), 32'h1);
    req1 = 2'b00;
    tick();

    // inputs wiggle after grant: captured values win
    req1 = 2'b01; a0_1 = 2'd3; d0_1 = 4'h9;
    q1.push_back('{0, 2'd3, 4'h9});
    tick();
    for (int k = 0; k < 10 && ack1 == 2'b00; k++) begin
      a0_1 = 2'(k);
      d0_1 = 4'(k + 1);
      tick();
    end
    chk("wig_ack", 32'(ack1), 32'h1);
    req1 = 2'b00;
    tick();
    chk("wig_other_word", 32'(mem1[1]), 32'hC);

    // GATE_CYCLES=3 preset of word 3 by requester 1
    req3 = 2'b10; op3 = 2'b10; a1_3 = 2'd3; d1_3 = 4'h2;
    q3.push_back('{1, 2'd3, 4'hF});
    tick();
    chk("p_setup_ld", 32'(ld3), 32'hF);
    chk("p_setup_lpre", 32'(lpre3), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("p_gate_lpre", 32'(lpre3), 32'h8);
      chk("p_gate_lgn", 32'(lgn3), 32'hF);
      chk("p_gate_ld", 32'(ld3), 32'hF);
    end
    tick();
    chk("p_hold_ack", 32'(ack3), 32'h2);
    chk("p_hold_lpre", 32'(lpre3), 0);
    req3 = 2'b00;
    tick();

    for (int t = 0; t < 20 && (q1.size() != 0 || q3.size() != 0); t++)
      tick();
    chk("q1_drain", 32'(q1.size()), 0);
    chk("q3_drain", 32'(q3.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/latch_bank_write_ctrl.md
# latch_bank_write_ctrl

Synchronous controller that sequences writes and presets into a bank of 4-bit transparent latches with active-low gates and active-high preset. Two requesters share the bank through a round-robin arbiter. The controller places data on a shared D bus, then pulses exactly one word's gate or preset inside a setup/hold window, all on one clock. It sits between the clocked requesters and the latch bank, and is the only driver of the bank's D, G and PRE inputs.

## Interface
Parameters:
- WIDTH, 4, latch word width.
- ADDR_W, 2, word address width; WORDS = 2**ADDR_W (derived, not overridable).
- GATE_CYCLES, 1, cycles the gate or preset is held active (≥1).
- INIT_PRESET, 1, when 1, every word is preset to all-ones once after reset.

Ports (all uppercase):
- C  in  1  clock, rising edge.
- R  in  1  reset; one clock, synchronous, active-high.
- REQ  in  2  request per requester; held high until that requester's ACK.
- OP  in  2  per-requester operation: 0 = write DATA, 1 = preset word.
- ADDR0, ADDR1  in  ADDR_W  target word per requester.
- DATA0, DATA1  in  WIDTH  write data per requester.
- ACK  out  2  one-cycle completion pulse per requester.
- LD  out  WIDTH  shared latch data bus.
- LG_N  out  WORDS  per-word gate, active-low, idle high.
- LPRE  out  WORDS  per-word preset, active-high, idle low.
- BUSY  out  1  high whenever the state is not IDLE.

## Operation
- States: INIT, IDLE, SETUP, GATE, HOLD.
- Reset: in the cycle after R is sampled high, outputs are LG_N = all ones, LPRE = 0, LD = 0, ACK = 0. Priority pointer = requester 0. The next state is INIT if INIT_PRESET is 1, otherwise IDLE.
- INIT: LPRE = all ones for GATE_CYCLES cycles, BUSY = 1, then go to IDLE. Requests are ignored during INIT.
- IDLE: if any REQ bit is high, grant one requester. If only one bit is high, that requester wins. If both are high, the priority-pointer requester wins. The winner's OP, ADDR and DATA are captured into registers. The pointer moves to the other requester, and the state goes to SETUP.
- SETUP (1 cycle): LD = captured DATA for a write, or all ones for a preset. All gates are inactive.
- GATE (GATE_CYCLES cycles): LD is unchanged. For a write, LG_N[addr] = 0. For a preset, LPRE[addr] = 1. All other words stay inactive.
- HOLD (1 cycle): gate or preset is released, LD is unchanged, and the granted requester's ACK = 1. The next state is IDLE.
- LD keeps its last value in IDLE; it changes only on entry to SETUP.
- Invariant: at most one LG_N bit is low and at most one LPRE bit is high in any cycle. LG_N low and LPRE high never occur in the same cycle. INIT is the only exception, where all LPRE bits are high together.
- The requester must drop REQ in the cycle after ACK. A REQ still high in that IDLE cycle is treated as a new request.
- Changes to REQ, OP, ADDR or DATA after the grant have no effect on the operation in flight.
- Reset mid-operation: the next cycle releases every gate and preset. No ACK is issued. The target word content is undefined, and the requester must re-issue.

## Timing
- Cycle 0: IDLE with REQ sampled high.
- Cycle 1: SETUP.
- Cycles 2 to 1+GATE_CYCLES: GATE.
- Cycle 2+GATE_CYCLES: HOLD with ACK high.
- Cycle 3+GATE_CYCLES: IDLE, next grant possible.
- Throughput: one operation per 3+GATE_CYCLES cycles.
- All outputs come directly from registers, so there are no combinational paths from inputs to outputs.
- The losing requester waits at most one full operation when both request continuously; the two strictly alternate.

## Structure
- Package latch_ctrl_pkg holds the state encoding (INIT, IDLE, SETUP, GATE, HOLD) and the OP constants OP_WRITE = 0 and OP_PRESET = 1.
- Sub-module rr_arb2: a two-input round-robin arbiter. It has grant one-hot output, an advance input and a registered pointer. Its reset is the same synchronous R.
- The top level contains the FSM, the GATE_CYCLES down-counter, the capture registers and the address decode.

## Test plan
- Reset with INIT_PRESET = 1, GATE_CYCLES = 1:
  - Cycle after R: LG_N = 4'b1111, LPRE = 0, ACK = 0.
  - Next cycle: LPRE = 4'b1111 for 1 cycle, BUSY high; then IDLE.
- REQ[0] alone, write DATA0 = 4'hA, ADDR0 = 2:
  - LD = 4'hA from cycle 1.
  - LG_N = 4'b1011 in cycle 2 only.
  - ACK[0] in cycle 3; the latch model holds 4'hA.
- Both REQ held high from reset, both writes:
  - Grants alternate 0, 1, 0, 1.
  - ACK pulses every 4 cycles, never both in the same cycle.
- REQ[1] preset, ADDR1 = 3, GATE_CYCLES = 3:
  - LPRE = 4'b1000 for 3 cycles; LD = 4'hF throughout; LG_N stays all ones.
  - ACK[1] in cycle 5.
- R asserted during the GATE cycle:
  - Next cycle: LG_N all ones, LPRE = 0, no ACK.
  - A re-issued request completes normally.
- ADDR0 and DATA0 changed every cycle after the grant: the latched word equals the values captured at the grant.
